// File: rtl/bus_arbiter_if.sv
// Bus arbiter interface bundle.
// Groups the four-requester request/data lines and the arbitrated bus outputs.
//   req  [3:0]          : per-requester bus request, bit i = requester i
//   din  [4*WIDTH-1:0]  : packed requester data, slot i at [i*WIDTH +: WIDTH]
//   a    [WIDTH-1:0]    : registered bus word for the downstream tristate data input
//   en                  : registered drive enable for the downstream tristate driver
//   gnt  [3:0]          : registered one-hot grant, zero when the bus has no owner
//   busy                : high whenever the arbiter is not idle
// Handshake: a requester raises req[i] and holds it for as long as it wants the
// bus; ownership starts on the edge that returns gnt[i]=1 (en=1, a=slot i) and
// ends on the edge after req[i] is seen low or the hold limit is reached. Every
// tenure is followed by one turnaround cycle with en=0 and gnt=0.
interface bus_arbiter_if #(
  parameter int WIDTH = 8
);
  logic [3:0]         req;
  logic [4*WIDTH-1:0] din;
  logic [WIDTH-1:0]   a;
  logic               en;
  logic [3:0]         gnt;
  logic               busy;

  // Requester side drives the requests and data.
  modport master (output req, din, input a, en, gnt, busy);
  // Arbiter side.
  modport slave (input req, din, output a, en, gnt, busy);
endinterface

// File: rtl/bus_arbiter.sv
// Four-way round-robin bus arbiter with bounded tenure and a one-cycle bus
// turnaround between owners, driving a registered tristate data/enable pair.
// Ports:
//   clk         : clock, all state changes on rising edge
//   rst         : asynchronous active-high reset
//   bus         : bus_arbiter_if slave modport (req, din in; a, en, gnt, busy out)
//   dbg_state_o : current FSM state (0=IDLE, 1=GRANT, 2=TURN)
module bus_arbiter #(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic         clk,
  input  logic         rst,
  bus_arbiter_if.slave bus,
  output logic [1:0]   dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  state_t             state_q;
  logic [1:0]         ptr_q;
  logic [1:0]         owner_q;
  logic [3:0]         tenure_q;
  logic [WIDTH-1:0]   a_q;
  logic               en_q;
  logic [3:0]         gnt_q;
  logic               busy_q;

  // Round-robin winner search, starting at ptr_q and wrapping 3->0.
  logic               win_valid_d;
  logic [1:0]         win_idx_d;
  logic [1:0]         probe_idx;
  logic [WIDTH-1:0]   win_data_d;
  logic [WIDTH-1:0]   own_data_d;
  logic               release_d;

  always_comb begin
    win_valid_d = 1'b0;
    win_idx_d   = ptr_q;
    probe_idx   = ptr_q;
    for (int k = 0; k < 4; k++) begin
      probe_idx = ptr_q + 2'(k);
      if (!win_valid_d && bus.req[probe_idx]) begin
        win_valid_d = 1'b1;
        win_idx_d   = probe_idx;
      end
    end
  end

  assign win_data_d = bus.din[win_idx_d*WIDTH +: WIDTH];
  assign own_data_d = bus.din[owner_q*WIDTH +: WIDTH];

  // Tenure ends when the owner lets go or has used its full hold allowance.
  assign release_d = !bus.req[owner_q] || (tenure_q == 4'(MAX_HOLD));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= 2'd0;
      owner_q  <= 2'd0;
      tenure_q <= 4'd0;
      a_q      <= '0;
      en_q     <= 1'b0;
      gnt_q    <= 4'd0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        // IDLE and TURN arbitrate identically; TURN only differs in that
        // ptr_q has just been advanced past the previous owner.
        IDLE, TURN: begin
          if (win_valid_d) begin
            state_q  <= GRANT;
            owner_q  <= win_idx_d;
            tenure_q <= 4'd1;
            a_q      <= win_data_d;
            en_q     <= 1'b1;
            gnt_q    <= 4'b0001 << win_idx_d;
            busy_q   <= 1'b1;
          end else begin
            state_q  <= IDLE;
            tenure_q <= 4'd0;
            a_q      <= '0;
            en_q     <= 1'b0;
            gnt_q    <= 4'd0;
            busy_q   <= 1'b0;
          end
        end
        GRANT: begin
          if (release_d) begin
            state_q  <= TURN;
            ptr_q    <= owner_q + 2'd1;
            tenure_q <= 4'd0;
            a_q      <= '0;
            en_q     <= 1'b0;
            gnt_q    <= 4'd0;
            busy_q   <= 1'b1;
          end else begin
            a_q      <= own_data_d;
            tenure_q <= tenure_q + 4'd1;
          end
        end
        default: begin
          state_q  <= IDLE;
          a_q      <= '0;
          en_q     <= 1'b0;
          gnt_q    <= 4'd0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.a       = a_q;
  assign bus.en      = en_q;
  assign bus.gnt     = gnt_q;
  assign bus.busy    = busy_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter WIDTH, default 8: data width of each requester slot and of the bus word.
REQ-002 Parameter MAX_HOLD, default 4: maximum consecutive grant cycles per tenure; legal range 1..15.
REQ-003 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous and active-high.
REQ-005 Port req, input, 4: per-requester bus request; bit i belongs to requester i.
REQ-006 Port din, input, 4*WIDTH: requester data, packed; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-007 Port a, output, WIDTH: registered bus word feeding the downstream tristate driver's data input.
REQ-008 Port en, output, 1: registered drive enable feeding the downstream tristate driver's enable input.
REQ-009 Port gnt, output, 4: registered one-hot grant; all-zero when no owner.
REQ-010 Port busy, output, 1: high in any state other than IDLE.

Function
REQ-011 The block SHALL implement three states: IDLE, GRANT and TURN.
REQ-012 All outputs SHALL be registered; a, en and gnt SHALL change only on clk edges or on rst.
REQ-013 Arbitration SHALL be round-robin: search req starting at index ptr, wrapping 3->0, and select the first set bit.
REQ-014 IDLE: en=0, gnt=0, a=0; any set req bit sampled on an edge -> GRANT with the winner's gnt bit and en=1 valid after that same edge, for one-cycle request-to-drive latency.
REQ-015 GRANT: each edge, a SHALL load din slot of the granted requester, so the bus tracks owner data with one cycle of latency.
REQ-016 GRANT: an internal tenure counter SHALL count grant cycles, with 1 in the first grant cycle.
REQ-017 GRANT -> TURN when req[owner]=0 is sampled or the tenure counter equals MAX_HOLD, whichever occurs first.
REQ-018 On entering TURN: en=0, gnt=0, a=0, ptr=owner+1 mod 4.
REQ-019 TURN SHALL last exactly one cycle as a bus turnaround, so no two requesters are ever driven on consecutive cycles.
REQ-020 TURN: arbitration SHALL use the updated ptr; any req set -> GRANT, else -> IDLE.
REQ-021 en SHALL equal the OR of gnt at every cycle, and gnt SHALL never have more than one bit set.
REQ-022 A requester that raises req while another owns the bus SHALL wait; it SHALL be granted no later than the 3rd TURN after that point.
REQ-023 Changes to non-owner req bits during GRANT SHALL have no effect on the current tenure.
REQ-024 When MAX_HOLD forces release and the same requester still holds req with no other requester set, that requester SHALL be re-granted after the TURN cycle.
REQ-025 When several req bits rise on the same edge in IDLE, only the round-robin winner SHALL be granted.

Reset
REQ-026 Asserting rst SHALL immediately, without waiting for a clock, force state=IDLE, a=0, en=0, gnt=0, busy=0, ptr=0 and tenure counter=0.
REQ-027 rst asserted mid-tenure SHALL drop en within the same cycle; after release, the first grant SHALL follow REQ-014 using ptr=0.
REQ-028 After rst deasserts, the first edge SHALL evaluate req normally, with no extra wait cycles.

Verification
REQ-029 Single requester: rst pulse, req=0001, din slot0=8'hCC held 3 cycles then req=0 -> en=1, gnt=0001 and a=8'hCC for 3 cycles, then 1 TURN cycle (en=0), then IDLE.
REQ-030 Forced release: req=0100 held 10 cycles, MAX_HOLD=4 -> pattern of 4 cycles en=1 and gnt=0100, then 1 cycle en=0, repeated; a=slot2 data while en=1.
REQ-031 Round-robin: req=1111 held, each requester drops after 2 grant cycles and reasserts -> gnt sequence 0001,0010,0100,1000,0001, with one en=0 cycle between each.
REQ-032 Simultaneous request: from reset, req=1010 on the same edge -> gnt=0010 first, then gnt=1000 after the TURN cycle.
REQ-033 Async reset: rst pulsed between edges during gnt=0100 -> en=0, gnt=0, a=8'h00 before the next edge; the next grant with req=1111 is gnt=0001.
REQ-034 Every scenario: checker flags any cycle with gnt not one-hot-or-zero, en != OR(gnt), or two different gnt values on adjacent cycles.
